ram_port_arbiter: RTL and testbench

//  Shares the single RAM port between two masters: master 0 is the CPU/ALU

---
 rtl/ram_port_arbiter_if.sv | 24 ++
 rtl/ram_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Request/ack bundle shared by the two masters and the RAM side of ram_port_arbiter.
// dataOut always flows toward the RAM; dataIn always flows back toward the requester.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataOut;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  readReq;
  logic                  writeReq;
  logic                  readAck;
  logic                  writeAck;

  modport master (
    output address, dataOut, readReq, writeReq,
    input  dataIn, readAck, writeAck
  );

  modport slave (
    input  address, dataOut, readReq, writeReq,
    output dataIn, readAck, writeAck
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between two pulse-handshake masters,
// with per-master request capture, ack/data return routing and a RAM-ack timeout.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   m0,
  ram_port_arbiter_if.slave   m1,
  ram_port_arbiter_if.master  mem,
  output logic [2:0]          errStatus
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic                  GUARD_ON   = (TIMEOUT != 0);
  localparam logic [15:0]           WAIT_LIMIT = 16'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] DEAD_WORD  = DATA_WIDTH'(32'hdeadbeef);

  state_t                state_r, nextState_s;
  logic [1:0]            pend_r, isWrite_r;
  logic [ADDR_WIDTH-1:0] addr_r    [2];
  logic [DATA_WIDTH-1:0] data_r    [2];
  logic [DATA_WIDTH-1:0] rdData_r  [2];
  logic [1:0]            rdAck_r, wrAck_r;
  logic                  lastGrant_r, owner_r, ownerWrite_r;
  logic [15:0]           waitCnt_r;
  logic [ADDR_WIDTH-1:0] memAddr_r;
  logic [DATA_WIDTH-1:0] memData_r;
  logic                  memRd_r, memWr_r;

  logic                  grant_s, issue_s, ackHit_s, timeout_s;
  logic [1:0]            rdReq_s, wrReq_s;
  logic [ADDR_WIDTH-1:0] reqAddr_s [2];
  logic [DATA_WIDTH-1:0] reqData_s [2];

  assign rdReq_s      = {m1.readReq, m0.readReq};
  assign wrReq_s      = {m1.writeReq, m0.writeReq};
  assign reqAddr_s[0] = m0.address;
  assign reqAddr_s[1] = m1.address;
  assign reqData_s[0] = m0.dataOut;
  assign reqData_s[1] = m1.dataOut;

  assign mem.address  = memAddr_r;
  assign mem.dataOut  = memData_r;
  assign mem.readReq  = memRd_r;
  assign mem.writeReq = memWr_r;
  assign m0.dataIn    = rdData_r[0];
  assign m0.readAck   = rdAck_r[0];
  assign m0.writeAck  = wrAck_r[0];
  assign m1.dataIn    = rdData_r[1];
  assign m1.readAck   = rdAck_r[1];
  assign m1.writeAck  = wrAck_r[1];

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode: grant selection in IDLE, ack match or timeout in WAIT
  always_comb begin
    nextState_s = state_r;
    grant_s     = 1'b0;
    issue_s     = 1'b0;
    ackHit_s    = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_r == 2'b11) begin
          grant_s     = ~lastGrant_r;
          issue_s     = 1'b1;
          nextState_s = WAIT;
        end else if (pend_r != 2'b00) begin
          grant_s     = pend_r[1];
          issue_s     = 1'b1;
          nextState_s = WAIT;
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT: begin
        // Only the ack type matching the owner's request ends the transaction
        if ((ownerWrite_r && mem.writeAck) || (!ownerWrite_r && mem.readAck)) begin
          ackHit_s    = 1'b1;
          nextState_s = IDLE;
        end else if (GUARD_ON && (waitCnt_r == WAIT_LIMIT)) begin
          timeout_s   = 1'b1;
          nextState_s = IDLE;
        end else begin
          nextState_s = WAIT;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Datapath: request capture, RAM issue, ack/data routing and sticky errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r       <= 2'b00;
      isWrite_r    <= 2'b00;
      rdAck_r      <= 2'b00;
      wrAck_r      <= 2'b00;
      lastGrant_r  <= 1'b1;
      owner_r      <= 1'b0;
      ownerWrite_r <= 1'b0;
      waitCnt_r    <= 16'd0;
      memAddr_r    <= {ADDR_WIDTH{1'b0}};
      memData_r    <= {DATA_WIDTH{1'b0}};
      memRd_r      <= 1'b0;
      memWr_r      <= 1'b0;
      errStatus    <= 3'b000;
      for (int i = 0; i < 2; i++) begin
        addr_r[i]   <= {ADDR_WIDTH{1'b0}};
        data_r[i]   <= {DATA_WIDTH{1'b0}};
        rdData_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      memRd_r <= 1'b0;
      memWr_r <= 1'b0;
      rdAck_r <= 2'b00;
      wrAck_r <= 2'b00;

      if (issue_s) begin
        memAddr_r    <= addr_r[grant_s];
        memData_r    <= data_r[grant_s];
        memRd_r      <= ~isWrite_r[grant_s];
        memWr_r      <= isWrite_r[grant_s];
        waitCnt_r    <= 16'd0;
        lastGrant_r  <= grant_s;
        owner_r      <= grant_s;
        ownerWrite_r <= isWrite_r[grant_s];
      end else if (state_r == WAIT) begin
        waitCnt_r <= waitCnt_r + 16'd1;
      end

      // A timed-out owner still gets its ack so it never hangs
      if (ackHit_s || timeout_s) begin
        pend_r[owner_r] <= 1'b0;
        if (ownerWrite_r) begin
          wrAck_r[owner_r] <= 1'b1;
        end else begin
          rdAck_r[owner_r]  <= 1'b1;
          rdData_r[owner_r] <= ackHit_s ? mem.dataIn : DEAD_WORD;
        end
      end

      if (timeout_s) begin
        errStatus[0] <= 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
        if (rdReq_s[i] || wrReq_s[i]) begin
          if (pend_r[i] || (rdReq_s[i] && wrReq_s[i])) begin
            errStatus[i+1] <= 1'b1;
          end else begin
            pend_r[i]    <= 1'b1;
            addr_r[i]    <= reqAddr_s[i];
            data_r[i]    <= reqData_s[i];
            isWrite_r[i] <= wrReq_s[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: single read, simultaneous requests,
// round-robin fairness, timeout, overrun errors and reset mid-transaction.
module tb_ram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] errStatus;
  int         nChecks = 0;
  int         nFails  = 0;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0If ();
  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1If ();
  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) memIf ();

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0If),
    .m1        (m1If),
    .mem       (memIf),
    .errStatus (errStatus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    m0If.address = 32'h0; m0If.dataOut = 32'h0; m0If.readReq = 1'b0; m0If.writeReq = 1'b0;
    m1If.address = 32'h0; m1If.dataOut = 32'h0; m1If.readReq = 1'b0; m1If.writeReq = 1'b0;
    memIf.dataIn = 32'h0; memIf.readAck = 1'b0; memIf.writeAck = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    clearInputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clearInputs();
    tick();
    tick();
    nChecks++;
    if ({memIf.readReq, memIf.writeReq, m0If.readAck, m0If.writeAck, m1If.readAck, m1If.writeAck, errStatus} !== 9'b0) begin
      nFails++;
      $display("FAIL reset_ctrl: got %b want 000000000", {memIf.readReq, memIf.writeReq, m0If.readAck, m0If.writeAck, m1If.readAck, m1If.writeAck, errStatus});
    end
    nChecks++;
    if ({memIf.address, memIf.dataOut, m0If.dataIn, m1If.dataIn} !== 128'h0) begin
      nFails++;
      $display("FAIL reset_data: got %h want 0", {memIf.address, memIf.dataOut, m0If.dataIn, m1If.dataIn});
    end
    reset = 1'b1;
    tick();
    nChecks++;
    if (memIf.readReq !== 1'b0 || memIf.writeReq !== 1'b0) begin
      nFails++;
      $display("FAIL reset_idle: got rd=%b wr=%b want 0 0", memIf.readReq, memIf.writeReq);
    end
  endtask

  task automatic test_single_read();
    applyReset();
    m0If.address = 32'h10; m0If.readReq = 1'b1;
    tick();
    m0If.readReq = 1'b0;
    nChecks++;
    if (memIf.readReq !== 1'b0) begin
      nFails++; $display("FAIL rd_capture_cycle: memReadReq=%b want 0", memIf.readReq);
    end
    tick();
    nChecks++;
    if (memIf.readReq !== 1'b1 || memIf.address !== 32'h10 || memIf.writeReq !== 1'b0) begin
      nFails++; $display("FAIL rd_issue: rd=%b wr=%b addr=%h want 1 0 00000010", memIf.readReq, memIf.writeReq, memIf.address);
    end
    tick();
    nChecks++;
    if (memIf.readReq !== 1'b0) begin
      nFails++; $display("FAIL rd_req_pulse: memReadReq=%b want 0", memIf.readReq);
    end
    tick();
    memIf.readAck = 1'b1; memIf.dataIn = 32'h12345678;
    tick();
    memIf.readAck = 1'b0; memIf.dataIn = 32'h0;
    nChecks++;
    if (m0If.readAck !== 1'b1 || m0If.dataIn !== 32'h12345678) begin
      nFails++; $display("FAIL rd_ack: ack=%b data=%h want 1 12345678", m0If.readAck, m0If.dataIn);
    end
    nChecks++;
    if ({m1If.readAck, m1If.writeAck, m1If.dataIn, m0If.writeAck} !== 35'h0) begin
      nFails++; $display("FAIL rd_other_quiet: got %h want 0", {m1If.readAck, m1If.writeAck, m1If.dataIn, m0If.writeAck});
    end
    tick();
    nChecks++;
    if (m0If.readAck !== 1'b0 || m0If.dataIn !== 32'h12345678) begin
      nFails++; $display("FAIL rd_ack_pulse_hold: ack=%b data=%h want 0 12345678", m0If.readAck, m0If.dataIn);
    end
  endtask

  task automatic test_simultaneous();
    applyReset();
    m0If.address = 32'h20; m0If.readReq = 1'b1;
    m1If.address = 32'h40; m1If.dataOut = 32'hCAFEF00D; m1If.writeReq = 1'b1;
    tick();
    m0If.readReq = 1'b0; m1If.writeReq = 1'b0;
    tick();
    nChecks++;
    if (memIf.readReq !== 1'b1 || memIf.writeReq !== 1'b0 || memIf.address !== 32'h20) begin
      nFails++; $display("FAIL sim_first_m0: rd=%b wr=%b addr=%h want 1 0 00000020", memIf.readReq, memIf.writeReq, memIf.address);
    end
    memIf.readAck = 1'b1; memIf.dataIn = 32'h55AA55AA;
    tick();
    memIf.readAck = 1'b0;
    nChecks++;
    if (m0If.readAck !== 1'b1 || m0If.dataIn !== 32'h55AA55AA || memIf.writeReq !== 1'b0) begin
      nFails++; $display("FAIL sim_m0_ack: ack=%b data=%h memWr=%b want 1 55aa55aa 0", m0If.readAck, m0If.dataIn, memIf.writeReq);
    end
    tick();
    nChecks++;
    if (memIf.writeReq !== 1'b1 || memIf.address !== 32'h40 || memIf.dataOut !== 32'hCAFEF00D) begin
      nFails++; $display("FAIL sim_m1_b2b: wr=%b addr=%h data=%h want 1 00000040 cafef00d", memIf.writeReq, memIf.address, memIf.dataOut);
    end
    memIf.writeAck = 1'b1;
    tick();
    memIf.writeAck = 1'b0;
    nChecks++;
    if (m1If.writeAck !== 1'b1 || m0If.readAck !== 1'b0 || m1If.readAck !== 1'b0) begin
      nFails++; $display("FAIL sim_m1_ack: m1wr=%b m0rd=%b m1rd=%b want 1 0 0", m1If.writeAck, m0If.readAck, m1If.readAck);
    end
    tick();
    nChecks++;
    if (m1If.writeAck !== 1'b0 || dut.lastGrant_r !== 1'b1) begin
      nFails++; $display("FAIL sim_wack_pulse_grant: ack=%b lastGrant=%b want 0 1", m1If.writeAck, dut.lastGrant_r);
    end
  endtask

  task automatic test_round_robin();
    int waited;
    int obsOwner;
    applyReset();
    m0If.address = 32'h100; m0If.readReq = 1'b1;
    m1If.address = 32'h200; m1If.readReq = 1'b1;
    tick();
    m0If.readReq = 1'b0; m1If.readReq = 1'b0;
    for (int k = 0; k < 6; k++) begin
      waited = 0;
      while (memIf.readReq !== 1'b1 && waited < 20) begin
        tick();
        waited++;
      end
      obsOwner = (memIf.address[11:8] == 4'h2) ? 1 : 0;
      nChecks++;
      if (waited >= 20 || obsOwner != (k % 2)) begin
        nFails++; $display("FAIL rr_grant_%0d: owner=%0d waited=%0d want owner %0d", k, obsOwner, waited, k % 2);
      end
      memIf.readAck = 1'b1; memIf.dataIn = 32'hA0 + k;
      tick();
      memIf.readAck = 1'b0;
      nChecks++;
      if ((k % 2 == 0 && (m0If.readAck !== 1'b1 || m1If.readAck !== 1'b0)) ||
          (k % 2 == 1 && (m1If.readAck !== 1'b1 || m0If.readAck !== 1'b0))) begin
        nFails++; $display("FAIL rr_ack_%0d: m0=%b m1=%b want owner %0d", k, m0If.readAck, m1If.readAck, k % 2);
      end
      if (k < 4) begin
        if (k % 2 == 0) begin m0If.address = 32'h100 + k; m0If.readReq = 1'b1; end
        else begin m1If.address = 32'h200 + k; m1If.readReq = 1'b1; end
      end
      tick();
      m0If.readReq = 1'b0; m1If.readReq = 1'b0;
    end
    nChecks++;
    if (errStatus !== 3'b000) begin
      nFails++; $display("FAIL rr_no_err: errStatus=%b want 000", errStatus);
    end
  endtask

  task automatic test_timeout();
    int n;
    applyReset();
    m1If.address = 32'h80; m1If.readReq = 1'b1;
    tick();
    m1If.readReq = 1'b0;
    tick();
    nChecks++;
    if (memIf.readReq !== 1'b1 || memIf.address !== 32'h80) begin
      nFails++; $display("FAIL to_issue: rd=%b addr=%h want 1 00000080", memIf.readReq, memIf.address);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (m1If.readAck !== 1'b1 && n < 20);
    nChecks++;
    if (n != 8) begin
      nFails++; $display("FAIL to_latency: got %0d cycles want 8", n);
    end
    nChecks++;
    if (m1If.dataIn !== 32'hdeadbeef || errStatus !== 3'b001 || m0If.readAck !== 1'b0) begin
      nFails++; $display("FAIL to_result: data=%h err=%b m0ack=%b want deadbeef 001 0", m1If.dataIn, errStatus, m0If.readAck);
    end
    m0If.address = 32'h30; m0If.readReq = 1'b1;
    tick();
    m0If.readReq = 1'b0;
    tick();
    nChecks++;
    if (memIf.readReq !== 1'b1 || memIf.address !== 32'h30) begin
      nFails++; $display("FAIL to_next_issue: rd=%b addr=%h want 1 00000030", memIf.readReq, memIf.address);
    end
    memIf.readAck = 1'b1; memIf.dataIn = 32'h0BADF00D;
    tick();
    memIf.readAck = 1'b0;
    nChecks++;
    if (m0If.readAck !== 1'b1 || m0If.dataIn !== 32'h0BADF00D || errStatus !== 3'b001) begin
      nFails++; $display("FAIL to_next_ack: ack=%b data=%h err=%b want 1 0badf00d 001", m0If.readAck, m0If.dataIn, errStatus);
    end
  endtask

  task automatic test_errors();
    logic sawReq;
    applyReset();
    m0If.address = 32'h50; m0If.readReq = 1'b1;
    tick();
    m0If.readReq = 1'b0;
    m0If.address = 32'h58; m0If.writeReq = 1'b1;
    m1If.address = 32'h70; m1If.readReq = 1'b1; m1If.writeReq = 1'b1;
    tick();
    clearInputs();
    nChecks++;
    if (errStatus !== 3'b110) begin
      nFails++; $display("FAIL err_bits: errStatus=%b want 110", errStatus);
    end
    nChecks++;
    if (memIf.readReq !== 1'b1 || memIf.writeReq !== 1'b0 || memIf.address !== 32'h50) begin
      nFails++; $display("FAIL err_first_only: rd=%b wr=%b addr=%h want 1 0 00000050", memIf.readReq, memIf.writeReq, memIf.address);
    end
    memIf.readAck = 1'b1; memIf.dataIn = 32'h00000050;
    tick();
    memIf.readAck = 1'b0;
    nChecks++;
    if (m0If.readAck !== 1'b1) begin
      nFails++; $display("FAIL err_first_ack: ack=%b want 1", m0If.readAck);
    end
    sawReq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (memIf.readReq === 1'b1 || memIf.writeReq === 1'b1) sawReq = 1'b1;
    end
    nChecks++;
    if (sawReq !== 1'b0 || errStatus !== 3'b110) begin
      nFails++; $display("FAIL err_dropped: extraReq=%b err=%b want 0 110", sawReq, errStatus);
    end
  endtask

  task automatic test_reset_mid();
    logic sawReq;
    applyReset();
    m0If.address = 32'h60; m0If.dataOut = 32'h11; m0If.writeReq = 1'b1;
    tick();
    m0If.writeReq = 1'b0;
    tick();
    nChecks++;
    if (memIf.writeReq !== 1'b1 || memIf.address !== 32'h60) begin
      nFails++; $display("FAIL rm_issue: wr=%b addr=%h want 1 00000060", memIf.writeReq, memIf.address);
    end
    #2;
    reset = 1'b0;
    #1;
    nChecks++;
    if (memIf.writeReq !== 1'b0 || memIf.address !== 32'h0 || memIf.dataOut !== 32'h0) begin
      nFails++; $display("FAIL rm_async_clear: wr=%b addr=%h data=%h want 0 0 0", memIf.writeReq, memIf.address, memIf.dataOut);
    end
    tick();
    reset = 1'b1;
    memIf.writeAck = 1'b1;
    tick();
    memIf.writeAck = 1'b0;
    nChecks++;
    if (m0If.writeAck !== 1'b0 || m1If.writeAck !== 1'b0 || 1'(dut.state_r) !== 1'b0) begin
      nFails++; $display("FAIL rm_late_ack: m0wr=%b m1wr=%b state=%b want 0 0 0", m0If.writeAck, m1If.writeAck, 1'(dut.state_r));
    end
    sawReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (memIf.readReq === 1'b1 || memIf.writeReq === 1'b1 || m0If.writeAck === 1'b1) sawReq = 1'b1;
    end
    nChecks++;
    if (sawReq !== 1'b0 || errStatus !== 3'b000 || memIf.address !== 32'h0) begin
      nFails++; $display("FAIL rm_abandoned: activity=%b err=%b addr=%h want 0 000 0", sawReq, errStatus, memIf.address);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
